// File: rtl/ct_f_spsram_1024x92_ctrl.sv
// Controller for a 1024x92 single-port SRAM: power-on/on-demand clear,
// lane-masked writes and a 2-entry read response buffer.
module ct_f_spsram_1024x92_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int WRAP_SIZE  = 23
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_vld,
    output logic                   req_rdy,
    input  logic                   req_wr,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [4*WRAP_SIZE-1:0] req_wdata,
    input  logic [3:0]             req_lane_en,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [4*WRAP_SIZE-1:0] rsp_data,
    input  logic                   init_req,
    output logic                   init_done,
    output logic [ADDR_WIDTH-1:0]  A,
    output logic                   CEN,
    output logic                   GWEN,
    output logic [4*WRAP_SIZE-1:0] WEN,
    output logic [4*WRAP_SIZE-1:0] D,
    input  logic [4*WRAP_SIZE-1:0] Q
);

    localparam int DW = 4 * WRAP_SIZE;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    rd_inflight_q, rd_inflight_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;
    logic                    wptr_q, wptr_d;
    logic                    rptr_q, rptr_d;
    logic [DW-1:0]           mem0_q, mem0_d;
    logic [DW-1:0]           mem1_q, mem1_d;

    logic                    push;
    logic                    pop;
    logic [2:0]              occ;
    logic                    rd_ok;
    logic                    xfer;

    // Occupancy counts the read still in the SRAM pipeline, net of a pop
    // happening this cycle, so a new read always finds a free slot.
    always_comb begin
        push      = rd_inflight_q;
        rsp_vld   = (fifo_cnt_q != 2'd0);
        pop       = rsp_vld && rsp_rdy;
        occ       = {1'b0, fifo_cnt_q} + {2'b00, rd_inflight_q}
                    - {2'b00, pop};
        rd_ok     = (occ < 3'd2);
        init_done = (state_q == ST_RUN);
        req_rdy   = (state_q == ST_RUN) && (req_wr || rd_ok);
        xfer      = req_vld && req_rdy;
        rsp_data  = '0;
        if (rsp_vld) begin
            rsp_data = rptr_q ? mem1_q : mem0_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = ADDR_WIDTH'(cnt_q + 1);
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!rd_inflight_q) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rd_inflight_d = xfer && !req_wr;
        fifo_cnt_d    = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        wptr_d        = wptr_q ^ push;
        rptr_d        = rptr_q ^ pop;
        mem0_d        = mem0_q;
        mem1_d        = mem1_q;
        if (push) begin
            if (wptr_q) begin
                mem1_d = Q;
            end else begin
                mem0_d = Q;
            end
        end
    end

    // SRAM pins are forced idle while reset is held.
    always_comb begin
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        A    = '0;
        D    = '0;
        if (!RST) begin
            if (state_q == ST_INIT) begin
                CEN  = 1'b0;
                GWEN = 1'b0;
                WEN  = '0;
                A    = cnt_q;
            end else if (xfer) begin
                CEN = 1'b0;
                A   = req_addr;
                if (req_wr) begin
                    D    = req_wdata;
                    GWEN = ~|req_lane_en;
                    for (int i = 0; i < 4; i++) begin
                        WEN[i*WRAP_SIZE +: WRAP_SIZE] =
                            {WRAP_SIZE{~req_lane_en[i]}};
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            rd_inflight_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            wptr_q        <= 1'b0;
            rptr_q        <= 1'b0;
            mem0_q        <= '0;
            mem1_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_inflight_q <= rd_inflight_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            mem0_q        <= mem0_d;
            mem1_q        <= mem1_d;
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_1024x92_ctrl.sv
// Directed bench for ct_f_spsram_1024x92_ctrl with a behavioural SRAM.
module tb_ct_f_spsram_1024x92_ctrl;

    logic        CLK;
    logic        RST;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [9:0]  req_addr;
    logic [91:0] req_wdata;
    logic [3:0]  req_lane_en;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [91:0] rsp_data;
    logic        init_req;
    logic        init_done;
    logic [9:0]  A;
    logic        CEN;
    logic        GWEN;
    logic [91:0] WEN;
    logic [91:0] D;
    logic [91:0] Q;

    logic [91:0] sram [1024];

    int checks;
    int errors;

    ct_f_spsram_1024x92_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_lane_en (req_lane_en),
        .rsp_vld     (rsp_vld),
        .rsp_rdy     (rsp_rdy),
        .rsp_data    (rsp_data),
        .init_req    (init_req),
        .init_done   (init_done),
        .A           (A),
        .CEN         (CEN),
        .GWEN        (GWEN),
        .WEN         (WEN),
        .D           (D),
        .Q           (Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                sram[A] <= (sram[A] & WEN) | (D & ~WEN);
            end else begin
                Q <= sram[A];
            end
        end
    end

    task automatic chk(input string tag, input logic [91:0] got,
                       input logic [91:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [91:0] data,
                            input logic [3:0] lane);
        req_vld     = 1'b1;
        req_wr      = 1'b1;
        req_addr    = addr;
        req_wdata   = data;
        req_lane_en = lane;
        #1;
        chk("wr_rdy", req_rdy, 1);
        @(negedge CLK);
        req_vld = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] addr, output logic [91:0] data,
                           output int lat);
        int n;
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = addr;
        n = 0;
        #1;
        while (!req_rdy && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("rd_rdy", req_rdy, 1);
        @(negedge CLK);
        req_vld = 1'b0;
        lat = 1;
        while (!rsp_vld && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        data = rsp_data;
        rsp_rdy = 1'b1;
        @(negedge CLK);
        rsp_rdy = 1'b0;
    endtask

    task automatic wait_clear(input int start, output int n,
                              output logic saw_vld);
        n = start;
        saw_vld = 1'b0;
        while (!init_done && n < 2000) begin
            if (rsp_vld) saw_vld = 1'b1;
            @(negedge CLK);
            n++;
        end
    endtask

    logic [91:0] rd;
    logic [91:0] got_q [4];
    logic [91:0] exp_q [4];
    logic        acc;
    logic        saw;
    int          lat;
    int          bad;
    int          n;
    int          got;

    initial begin
        checks = 0;
        errors = 0;
        Q = '0;
        for (int i = 0; i < 1024; i++) begin
            sram[i] = {92{1'b1}} ^ 92'(i);
        end
        RST = 1'b1;
        req_vld = 1'b0;
        req_wr = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_lane_en = '0;
        rsp_rdy = 1'b0;
        init_req = 1'b0;

        repeat (3) @(negedge CLK);
        #1;
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_cen", CEN, 1);
        chk("rst_gwen", GWEN, 1);
        chk("rst_wen", WEN, {92{1'b1}});
        chk("rst_a", A, 0);
        chk("rst_d", D, 0);

        @(negedge CLK);
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            #1;
            if (CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== '0 || D !== '0 ||
                A !== 10'(i) || req_rdy !== 1'b0 || init_done !== 1'b0)
                bad++;
            @(negedge CLK);
        end
        chk("init_seq_bad", bad, 0);
        chk("init_done_up", init_done, 1);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (sram[i] !== '0) bad++;
        end
        chk("init_mem_zero", bad, 0);

        do_read(10'd0, rd, lat);
        chk("rd0_data", rd, 0);
        chk("rd0_lat", lat, 2);
        do_read(10'd1023, rd, lat);
        chk("rd1023_data", rd, 0);

        req_vld = 1'b1;
        req_wr = 1'b1;
        req_addr = 10'd5;
        req_wdata = {92{1'b1}};
        req_lane_en = 4'b0101;
        #1;
        chk("lane_cen", CEN, 0);
        chk("lane_gwen", GWEN, 0);
        chk("lane_a", A, 10'd5);
        chk("lane_wen", WEN,
            {23'h7fffff, 23'h0, 23'h7fffff, 23'h0});
        @(negedge CLK);
        req_vld = 1'b0;
        do_read(10'd5, rd, lat);
        chk("lane_data", rd, {23'h0, 23'h7fffff, 23'h0, 23'h7fffff});
        chk("lane_lat", lat, 2);

        req_vld = 1'b1;
        req_wr = 1'b1;
        req_addr = 10'd5;
        req_wdata = '0;
        req_lane_en = 4'b0000;
        #1;
        chk("nolane_rdy", req_rdy, 1);
        chk("nolane_cen", CEN, 0);
        chk("nolane_gwen", GWEN, 1);
        @(negedge CLK);
        req_vld = 1'b0;
        do_read(10'd5, rd, lat);
        chk("nolane_data", rd, {23'h0, 23'h7fffff, 23'h0, 23'h7fffff});

        req_vld = 1'b1;
        req_wr = 1'b1;
        req_addr = 10'd7;
        req_wdata = 92'h0abc_def0_1234_5678_9abc_def;
        req_lane_en = 4'b1111;
        #1;
        chk("raw_wr_rdy", req_rdy, 1);
        @(negedge CLK);
        req_wr = 1'b0;
        #1;
        chk("raw_rd_rdy", req_rdy, 1);
        @(negedge CLK);
        req_vld = 1'b0;
        @(negedge CLK);
        chk("raw_vld", rsp_vld, 1);
        chk("raw_data", rsp_data, 92'h0abc_def0_1234_5678_9abc_def);
        rsp_rdy = 1'b1;
        @(negedge CLK);
        rsp_rdy = 1'b0;

        exp_q[0] = 92'h111;
        exp_q[1] = 92'h2222;
        exp_q[2] = 92'h33333;
        exp_q[3] = 92'h444444;
        do_write(10'd1, 92'h111, 4'hf);
        do_write(10'd2, 92'h2222, 4'hf);
        do_write(10'd3, 92'h33333, 4'hf);
        do_write(10'd4, 92'h444444, 4'hf);
        req_vld = 1'b1;
        req_wr = 1'b0;
        req_addr = 10'd1;
        #1;
        chk("bp_rdy1", req_rdy, 1);
        @(negedge CLK);
        req_addr = 10'd2;
        #1;
        chk("bp_rdy2", req_rdy, 1);
        @(negedge CLK);
        req_addr = 10'd3;
        #1;
        chk("bp_rdy3", req_rdy, 0);
        @(negedge CLK);
        #1;
        chk("bp_rdy4", req_rdy, 0);
        chk("bp_head", rsp_data, 92'h111);
        @(negedge CLK);
        #1;
        chk("bp_rdy5", req_rdy, 0);
        rsp_rdy = 1'b1;
        #1;
        got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            if (rsp_vld) begin
                got_q[got] = rsp_data;
                got++;
            end
            acc = req_vld && req_rdy;
            @(negedge CLK);
            if (acc) begin
                if (req_addr == 10'd4) req_vld = 1'b0;
                else req_addr = req_addr + 10'd1;
            end
            #1;
        end
        rsp_rdy = 1'b0;
        chk("bp_count", got, 4);
        for (int k = 0; k < 4; k++) begin
            chk("bp_order", got_q[k], exp_q[k]);
        end
        @(negedge CLK);

        do_write(10'd9, 92'h9999, 4'hf);
        req_vld = 1'b1;
        req_wr = 1'b0;
        req_addr = 10'd9;
        #1;
        chk("drn_rd_rdy", req_rdy, 1);
        @(negedge CLK);
        req_vld = 1'b0;
        init_req = 1'b1;
        #1;
        chk("drn_run", init_done, 1);
        @(negedge CLK);
        init_req = 1'b0;
        #1;
        chk("drn_done_lo", init_done, 0);
        chk("drn_req_rdy", req_rdy, 0);
        chk("drn_cen", CEN, 1);
        chk("drn_vld", rsp_vld, 1);
        chk("drn_data", rsp_data, 92'h9999);
        @(negedge CLK);
        #1;
        chk("drn_init_cen", CEN, 0);
        chk("drn_init_a", A, 0);
        chk("drn_keep_data", rsp_data, 92'h9999);
        rsp_rdy = 1'b1;
        @(negedge CLK);
        rsp_rdy = 1'b0;
        #1;
        chk("drn_popped", rsp_vld, 0);
        init_req = 1'b1;
        @(negedge CLK);
        init_req = 1'b0;
        wait_clear(2, n, saw);
        chk("drn_clear_len", n, 1024);
        do_read(10'd9, rd, lat);
        chk("drn_cleared", rd, 0);

        do_write(10'd11, 92'h0bb, 4'hf);
        req_vld = 1'b1;
        req_wr = 1'b0;
        req_addr = 10'd11;
        #1;
        chk("rst_rd_rdy", req_rdy, 1);
        @(negedge CLK);
        req_vld = 1'b0;
        @(negedge CLK);
        chk("rst_pend_vld", rsp_vld, 1);
        RST = 1'b1;
        #1;
        chk("rst_mid_vld", rsp_vld, 0);
        chk("rst_mid_data", rsp_data, 0);
        chk("rst_mid_cen", CEN, 1);
        chk("rst_mid_done", init_done, 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_restart_cen", CEN, 0);
        chk("rst_restart_a", A, 0);
        wait_clear(0, n, saw);
        chk("rst_clear_len", n, 1024);
        chk("rst_no_rsp", saw, 0);
        do_read(10'd11, rd, lat);
        chk("rst_cleared", rd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ct_f_spsram_1024x92_ctrl.md
CT_F_SPSRAM_1024X92_CTRL -- requirements
Module: ct_f_spsram_1024x92_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SRAM address width; depth 2^ADDR_WIDTH entries.
REQ-002 Parameter WRAP_SIZE, default 23, lane width; data = 4 lanes = 92 bits.
REQ-003 Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
REQ-004 CLK  in  1  clock; all state changes on its rising edge.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 req_vld  in  1  request valid.
REQ-007 req_rdy  out  1  request ready; transfer on req_vld && req_rdy.
REQ-008 req_wr  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  10  entry address.
REQ-010 req_wdata  in  92  write data.
REQ-011 req_lane_en  in  4  per-lane write enable; bit i enables bits [23i+22:23i].
REQ-012 rsp_vld  out  1  read data valid.
REQ-013 rsp_rdy  in  1  read data accepted.
REQ-014 rsp_data  out  92  read data.
REQ-015 init_req  in  1  single-cycle pulse; requests a full re-clear.
REQ-016 init_done  out  1  high while in RUN.
REQ-017 A  out  10  SRAM address.
REQ-018 CEN  out  1  SRAM chip enable, active-low.
REQ-019 GWEN  out  1  SRAM global write enable, active-low.
REQ-020 WEN  out  92  SRAM bit write enable, active-low.
REQ-021 D  out  92  SRAM write data.
REQ-022 Q  in  92  SRAM read data; valid in the cycle after a read access.

Function
REQ-023 The FSM SHALL have states INIT, RUN and DRAIN.
REQ-024 INIT: counter 0..1023, one write per cycle: CEN=0, GWEN=0, WEN=all 0, D=0, A=counter; req_rdy=0.
REQ-025 INIT -> RUN after the write at counter 1023; the clear takes 1024 cycles.
REQ-026 RUN: on a transfer, CEN=0 and A=req_addr in the same cycle (combinational).
REQ-027 RUN read: GWEN=1 and WEN=all 1.
REQ-028 RUN write: GWEN=0, D=req_wdata, and WEN lane i = all 0 if req_lane_en[i], else all 1.
REQ-029 RUN write with req_lane_en=0 SHALL still be accepted, with GWEN=1 (no SRAM write).
REQ-030 No transfer: CEN=1, GWEN=1, WEN=all 1; A and D don't-care (drive 0).
REQ-031 Read latency: accepted at cycle N; Q captured at the end of N+1; rsp_vld visible from N+2.
REQ-032 Response buffer: 2-entry FIFO; in-order; rsp_data/rsp_vld from the head entry.
REQ-033 rd_inflight is a 1-bit flag set on the cycle a read is accepted.
REQ-034 Read accepted only if fifo_count + rd_inflight - (rsp_vld && rsp_rdy) < 2.
REQ-035 Write accepted in RUN regardless of FIFO state.
REQ-036 Transfers are processed in acceptance order.
REQ-037 Read-after-write to the same address in consecutive cycles SHALL return the new data.
REQ-038 Simultaneous FIFO push (Q capture) and pop SHALL keep the count unchanged; the FIFO never overflows.
REQ-039 init_req in RUN -> DRAIN; req_rdy=0.
REQ-040 DRAIN -> INIT once rd_inflight=0; FIFO contents preserved and still poppable.
REQ-041 init_req in INIT or DRAIN SHALL be ignored.
REQ-042 init_done = (state == RUN).

Reset
REQ-043 RST asserted: state=INIT, counter=0, FIFO empty, rd_inflight=0.
REQ-044 RST asserted: rsp_vld=0, rsp_data=0, req_rdy=0, init_done=0.
REQ-045 RST asserted: CEN=1, GWEN=1, WEN=all 1, A=0, D=0.
REQ-046 RST mid-operation discards in-flight reads and FIFO data.
REQ-047 After RST deasserts, a full clear restarts on the next edge.

Verification
REQ-048 Release reset -> 1024 zero writes on A=0..1023; init_done rises; a read of any address returns 0.
REQ-049 Write addr 5, data all-ones, lane_en=4'b0101, then read 5 -> rsp_data = lanes 0 and 2 ones, lanes 1 and 3 zero, rsp_vld 2 cycles after accept.
REQ-050 Back-to-back reads of addr 1..4 with rsp_rdy=0 -> only 2 accepted, req_rdy=0; rsp_rdy=1 drains in order; the rest proceed.
REQ-051 Write addr 7 then read addr 7 in the next cycle -> returns the new data.
REQ-052 init_req with a read in flight -> DRAIN one cycle, FIFO response still delivered; INIT clears memory; init_done returns after 1024 cycles.
REQ-053 RST pulse during a read with rsp_vld pending -> rsp_vld=0 immediately; the pending response is never delivered; the clear restarts.
